// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit (master) and memory (slave).
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register, stall skid buffer and branch redirect.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [31:0]         branch_target_i,
  fetch_unit_if.master        imem,
  output logic [31:0]         pc_o,
  output logic [31:0]         IF_ID_pc_o,
  output logic [31:0]         IF_ID_instr_o,
  output logic                IF_ID_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_count_o,
  output logic [31:0]         stall_count_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] redir_q, redir_d;

  logic        load_bubble;
  logic        load_mem;
  logic        load_skid;
  logic        clear_skid;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    load_bubble = 1'b0;
    load_mem    = 1'b0;
    load_skid   = 1'b0;
    clear_skid  = 1'b0;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (flush_i) begin
          load_bubble = 1'b1;
          clear_skid  = 1'b1;
          if (imem.imem_ack_i) begin
            pc_d = branch_target_i;
          end else begin
            redir_d = branch_target_i;
            state_d = S_DROP;
          end
        end else if (imem.imem_ack_i) begin
          pc_d = pc_q + 32'd4;
          if (stall_i) begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem.imem_data_i;
            state_d      = S_HOLD;
          end else begin
            load_mem = 1'b1;
          end
        end else if (!stall_i) begin
          load_bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          load_bubble = 1'b1;
          clear_skid  = 1'b1;
          pc_d        = branch_target_i;
          state_d     = S_FETCH;
        end else if (!stall_i) begin
          load_skid = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_DROP: begin
        // Outstanding wrong-path request: its data is thrown away on ack.
        if (flush_i) begin
          load_bubble = 1'b1;
          clear_skid  = 1'b1;
          if (imem.imem_ack_i) begin
            pc_d    = branch_target_i;
            state_d = S_FETCH;
          end else begin
            redir_d = branch_target_i;
          end
        end else begin
          if (!stall_i) load_bubble = 1'b1;
          if (imem.imem_ack_i) begin
            pc_d    = redir_q;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_skid) begin
      skid_pc_d    = '0;
      skid_instr_d = '0;
    end

    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (load_bubble) begin
      ifid_pc_d    = '0;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end else if (load_mem) begin
      ifid_pc_d    = pc_q;
      ifid_instr_d = imem.imem_data_i;
      ifid_valid_d = 1'b1;
    end else if (load_skid) begin
      ifid_pc_d    = skid_pc_q;
      ifid_instr_d = skid_instr_q;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      redir_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      redir_q      <= redir_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load_mem || load_skid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q != S_IDLE && stall_i) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;
`endif

  assign imem.imem_req_o  = (state_q == S_FETCH) || (state_q == S_DROP);
  assign imem.imem_addr_o = pc_q;
  assign pc_o             = pc_q;
  assign IF_ID_pc_o       = ifid_pc_q;
  assign IF_ID_instr_o    = ifid_instr_q;
  assign IF_ID_valid_o    = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then randomized traffic vs a transaction-level model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        flush;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt;
  logic [31:0] scnt;
`endif

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stall_i         (stall),
    .flush_i         (flush),
    .branch_target_i (target),
    .imem            (bus.master),
    .pc_o            (pc),
    .IF_ID_pc_o      (ifid_pc),
    .IF_ID_instr_o   (ifid_instr),
    .IF_ID_valid_o   (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count_o   (fcnt),
    .stall_count_o   (scnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } insn_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;

  // Transaction-level reference model
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_wrong_path;
  logic [31:0] m_redir;
  insn_t       m_pending[$];
  logic [31:0] m_ipc, m_instr;
  logic        m_valid;
  logic [31:0] m_fc, m_sc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic void retire(input logic [31:0] p, input logic [31:0] i, input logic v);
    m_ipc = p; m_instr = i; m_valid = v;
    if (v) m_fc = m_fc + 32'd1;
  endfunction

  function automatic void model_step(input bit r, input bit s, input bit st, input bit fl,
                                     input logic [31:0] t, input bit a, input logic [31:0] d);
    bit    req;
    bit    got;
    insn_t it;
    req = m_run && (m_pending.size() == 0);
    got = req && a;
    if (r) begin
      m_run = 0; m_pc = RST_PC; m_wrong_path = 0; m_redir = '0;
      m_pending.delete();
      m_ipc = '0; m_instr = '0; m_valid = 1'b0; m_fc = '0; m_sc = '0;
    end else if (!m_run) begin
      if (s) m_run = 1;
    end else begin
      if (st) m_sc = m_sc + 32'd1;
      if (fl) begin
        retire('0, '0, 1'b0);
        m_pending.delete();
        if (req && !a) begin
          m_wrong_path = 1; m_redir = t;
        end else begin
          m_wrong_path = 0; m_pc = t;
        end
      end else if (got && m_wrong_path) begin
        m_wrong_path = 0; m_pc = m_redir;
        if (!st) retire('0, '0, 1'b0);
      end else if (got) begin
        if (st) m_pending.push_back('{pc: m_pc, instr: d});
        else    retire(m_pc, d, 1'b1);
        m_pc = m_pc + 32'd4;
      end else if (m_pending.size() != 0) begin
        if (!st) begin
          it = m_pending.pop_front();
          retire(it.pc, it.instr, 1'b1);
        end
      end else if (!st) begin
        retire('0, '0, 1'b0);
      end
    end
  endfunction

  function automatic bit model_req();
    return m_run && (m_pending.size() == 0);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Drives one cycle of stimulus at the falling edge and queues the expected post-edge state.
  task automatic cyc(input bit r, input bit s, input bit st, input bit fl,
                     input logic [31:0] t, input bit a);
    logic [31:0] d;
    exp_t e;
    @(negedge clk);
    d = a ? mem_word(m_pc) : $urandom;
    rst = r; start = s; stall = st; flush = fl; target = t;
    bus.imem_ack_i = a; bus.imem_data_i = d;
    model_step(r, s, st, fl, t, a, d);
    e.pc = m_pc; e.req = model_req(); e.ipc = m_ipc; e.instr = m_instr;
    e.valid = m_valid; e.fc = m_fc; e.sc = m_sc;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pc_o", pc, e.pc);
        check("imem_addr_o", bus.imem_addr_o, e.pc);
        check("imem_req_o", {31'd0, bus.imem_req_o}, {31'd0, e.req});
        check("IF_ID_valid_o", {31'd0, ifid_valid}, {31'd0, e.valid});
        check("IF_ID_pc_o", ifid_pc, e.ipc);
        check("IF_ID_instr_o", ifid_instr, e.instr);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count_o", fcnt, e.fc);
        check("stall_count_o", scnt, e.sc);
`endif
      end
    end
  end

  initial begin : stim
    bit a, st, fl, s, r;
    logic [31:0] t;
    rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; target = '0;
    bus.imem_ack_i = 1'b0; bus.imem_data_i = '0;

    // Back-to-back acks: 0,4,8
    cyc(1,0,0,0,0,1); cyc(0,1,0,0,0,0);
    cyc(0,0,0,0,0,1); cyc(0,0,0,0,0,1); cyc(0,0,0,0,0,1);
    // Ack latency 2 at address 0
    cyc(1,0,0,0,0,0); cyc(0,1,0,0,0,0);
    cyc(0,0,0,0,0,0); cyc(0,0,0,0,0,0); cyc(0,0,0,0,0,1);
    // Stall while 0x8 acked with 0x4 in IF/ID, then release
    cyc(0,0,0,0,0,1); cyc(0,0,1,0,0,1); cyc(0,0,1,0,0,1);
    cyc(0,0,0,0,0,0); cyc(0,0,0,0,0,1);
    // Flush to 0x100 while 0x10 outstanding with latency 3
    cyc(0,0,0,0,0,0); cyc(0,0,0,1,32'h100,0); cyc(0,0,0,0,0,0);
    cyc(0,0,0,0,0,1); cyc(0,0,0,0,0,1); cyc(0,0,0,0,0,1);
    // Flush + stall + ack together, target 0x200
    cyc(0,0,1,1,32'h200,1); cyc(0,0,0,0,0,1);
    // Flush and stall ignored in IDLE
    cyc(1,0,0,0,0,0); cyc(0,0,1,1,32'h40,1); cyc(0,0,0,0,0,1);
    // Wrap at top of address space
    cyc(0,1,0,0,0,0); cyc(0,0,0,1,32'hFFFF_FFF8,1);
    cyc(0,0,0,0,0,1); cyc(0,0,0,0,0,1); cyc(0,0,0,0,0,1);
    // Reset while in HOLD; ack in reset cycle ignored; no request until start
    cyc(0,0,1,0,0,1); cyc(0,0,1,0,0,0); cyc(1,0,1,0,0,1);
    cyc(0,0,0,0,0,1); cyc(0,0,0,0,0,1); cyc(0,1,0,0,0,0); cyc(0,0,0,0,0,1);
    // Flush twice in DROP, then ack
    cyc(0,0,0,1,32'h300,0); cyc(0,0,0,1,32'h400,0); cyc(0,0,1,0,0,1); cyc(0,0,0,0,0,1);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      a  = ($urandom_range(0, 9) < 4);
      t  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cyc(r, s, st, fl, t, a);
    end

    cyc(0,0,0,0,0,0);
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
